// File: rtl/control_pkg.sv
// Shared definitions for the multicycle main control unit: state encoding,
// instruction field codes and the ALU operation classes used by the ALU control decoder.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WAIT    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ILLEGAL   = 4'd13,
    S_TIMEOUT   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_NE    = 3'b110;

  // br_eq/br_ne are internal: they gate pc_write with the live zero flag in BRANCH.
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       alu_start;
    logic       illegal;
    logic       timeout;
    logic       br_eq;
    logic       br_ne;
  } ctrl_t;

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] r;
    case (op)
      OP_ANDI: r = ALU_AND;
      OP_ORI:  r = ALU_OR;
      OP_SLTI: r = ALU_SLT;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic state_t decode_next(input logic [5:0] op);
    state_t r;
    case (op)
      OP_RTYPE:                         r = S_R_EXEC;
      OP_LW, OP_SW:                     r = S_MEM_ADDR;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: r = S_I_EXEC;
      OP_BEQ, OP_BNE:                   r = S_BRANCH;
      OP_J:                             r = S_JUMP;
      default:                          r = S_ILLEGAL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in, strobes and selects out.
interface control_multiciclo_if;

  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       alu_done_i;

  logic       pc_write_o;
  logic [1:0] pc_source_o;
  logic       iord_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic       alu_start_o;
  logic       illegal_o;
  logic       timeout_o;

  // Mult/div handshake: alu_start_o is a single-cycle request; the ALU answers with
  // alu_done_i, which is only honoured while the controller waits in R_WAIT.
  modport master (
    input  opcode_i, funct_i, zero_i, alu_done_i,
    output pc_write_o, pc_source_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
           reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, alu_start_o, illegal_o, timeout_o
  );

  modport slave (
    output opcode_i, funct_i, zero_i, alu_done_i,
    input  pc_write_o, pc_source_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
           reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
           alu_op_o, alu_start_o, illegal_o, timeout_o
  );

endinterface

// File: rtl/control_multiciclo.sv
// Multicycle main control FSM: fetch/decode/execute/memory/write-back sequencing with
// registered Moore outputs and a bounded wait for multi-cycle mult/div results.
module control_multiciclo
  import control_pkg::*;
#(
  parameter int MD_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  control_multiciclo_if.master bus,
  output state_t              state_o
);

  localparam logic [7:0] LP_WAIT_LAST = 8'(MD_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  ctrl_t      r_ctrl;

  state_t     w_next;
  ctrl_t      w_next_ctrl;
  logic       w_is_md;

  assign w_is_md = (bus.funct_i == FN_MULT) || (bus.funct_i == FN_DIV);

  // Done takes priority over the timeout limit when both occur in the same cycle.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE:   w_next = decode_next(bus.opcode_i);
      S_MEM_ADDR: w_next = (bus.opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: w_next = S_MEM_WB;
      S_R_EXEC:   w_next = w_is_md ? S_R_WAIT : S_R_WB;
      S_R_WAIT: begin
        if (bus.alu_done_i)              w_next = S_R_WB;
        else if (r_cnt == LP_WAIT_LAST)  w_next = S_TIMEOUT;
        else                             w_next = S_R_WAIT;
      end
      S_I_EXEC:   w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  // Outputs are decoded for the state being entered so they can be registered.
  always_comb begin
    w_next_ctrl = '0;
    case (w_next)
      S_FETCH: begin
        w_next_ctrl.mem_read  = 1'b1;
        w_next_ctrl.ir_write  = 1'b1;
        w_next_ctrl.pc_write  = 1'b1;
        w_next_ctrl.alu_src_b = 2'b01;
      end
      S_DECODE:   w_next_ctrl.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        w_next_ctrl.alu_src_a = 1'b1;
        w_next_ctrl.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        w_next_ctrl.mem_read = 1'b1;
        w_next_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        w_next_ctrl.reg_write  = 1'b1;
        w_next_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        w_next_ctrl.mem_write = 1'b1;
        w_next_ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        w_next_ctrl.alu_src_a = 1'b1;
        w_next_ctrl.alu_op    = ALU_RTYPE;
        w_next_ctrl.alu_start = w_is_md;
      end
      S_R_WAIT: begin
        w_next_ctrl.alu_src_a = 1'b1;
        w_next_ctrl.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        w_next_ctrl.reg_write = 1'b1;
        w_next_ctrl.reg_dst   = 1'b1;
        w_next_ctrl.alu_op    = ALU_RTYPE;
      end
      S_I_EXEC: begin
        w_next_ctrl.alu_src_a = 1'b1;
        w_next_ctrl.alu_src_b = 2'b10;
        w_next_ctrl.alu_op    = imm_alu_op(bus.opcode_i);
      end
      S_I_WB: begin
        w_next_ctrl.reg_write = 1'b1;
        w_next_ctrl.alu_op    = imm_alu_op(bus.opcode_i);
      end
      S_BRANCH: begin
        w_next_ctrl.alu_src_a = 1'b1;
        w_next_ctrl.alu_op    = ALU_SUB;
        w_next_ctrl.pc_source = 2'b01;
        w_next_ctrl.br_eq     = (bus.opcode_i == OP_BEQ);
        w_next_ctrl.br_ne     = (bus.opcode_i == OP_BNE);
      end
      S_JUMP: begin
        w_next_ctrl.pc_write  = 1'b1;
        w_next_ctrl.pc_source = 2'b10;
      end
      S_ILLEGAL:  w_next_ctrl.illegal = 1'b1;
      S_TIMEOUT:  w_next_ctrl.timeout = 1'b1;
      default:    w_next_ctrl = '0;
    endcase
  end

  // Reset loads the FETCH output pattern so the datapath sees it asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= S_FETCH;
      r_cnt              <= 8'd0;
      r_ctrl             <= '0;
      r_ctrl.mem_read    <= 1'b1;
      r_ctrl.ir_write    <= 1'b1;
      r_ctrl.pc_write    <= 1'b1;
      r_ctrl.alu_src_b   <= 2'b01;
    end else begin
      r_state <= w_next;
      r_ctrl  <= w_next_ctrl;
      r_cnt   <= (r_state == S_R_WAIT) ? r_cnt + 8'd1 : 8'd0;
    end
  end

  assign bus.pc_write_o   = r_ctrl.pc_write
                          | (r_ctrl.br_eq &  bus.zero_i)
                          | (r_ctrl.br_ne & ~bus.zero_i);
  assign bus.pc_source_o  = r_ctrl.pc_source;
  assign bus.iord_o       = r_ctrl.iord;
  assign bus.mem_read_o   = r_ctrl.mem_read;
  assign bus.mem_write_o  = r_ctrl.mem_write;
  assign bus.ir_write_o   = r_ctrl.ir_write;
  assign bus.reg_dst_o    = r_ctrl.reg_dst;
  assign bus.mem_to_reg_o = r_ctrl.mem_to_reg;
  assign bus.reg_write_o  = r_ctrl.reg_write;
  assign bus.alu_src_a_o  = r_ctrl.alu_src_a;
  assign bus.alu_src_b_o  = r_ctrl.alu_src_b;
  assign bus.alu_op_o     = r_ctrl.alu_op;
  assign bus.alu_start_o  = r_ctrl.alu_start;
  assign bus.illegal_o    = r_ctrl.illegal;
  assign bus.timeout_o    = r_ctrl.timeout;
  assign state_o          = r_state;

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: each instruction is expanded into its expected per-cycle
// control pattern from the instruction's class, then replayed against the DUT.
module tb_control_multiciclo;
  import control_pkg::*;

  localparam int W = 19;
  localparam int T = 4;

  logic   clk;
  logic   rst_n;
  state_t state_o;
  int     n_checks;
  int     n_errors;

  logic [W-1:0] exp_q[$];
  logic         done_q[$];

  control_multiciclo_if bus();

  control_multiciclo #(.MD_TIMEOUT(T)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ov(input logic pcw, input logic [1:0] pcs, input logic iord,
                                      input logic mr, input logic mw, input logic irw,
                                      input logic rd, input logic m2r, input logic rw,
                                      input logic a, input logic [1:0] b, input logic [2:0] op,
                                      input logic st, input logic ill, input logic to);
    return {pcw, pcs, iord, mr, mw, irw, rd, m2r, rw, a, b, op, st, ill, to};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.pc_write_o, bus.pc_source_o, bus.iord_o, bus.mem_read_o, bus.mem_write_o,
            bus.ir_write_o, bus.reg_dst_o, bus.mem_to_reg_o, bus.reg_write_o,
            bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.alu_start_o,
            bus.illegal_o, bus.timeout_o};
  endfunction

  function automatic logic [W-1:0] v_fetch();
    return ov(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 0, 0, 0);
  endfunction

  function automatic logic [2:0] imm_class(input logic [5:0] op);
    if (op == 6'b001100) return 3'b011;
    if (op == 6'b001101) return 3'b100;
    if (op == 6'b001010) return 3'b101;
    return 3'b000;
  endfunction

  task automatic push(input logic [W-1:0] v, input logic d);
    exp_q.push_back(v);
    done_q.push_back(d);
  endtask

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- reference model ----------------
  task automatic build_plan(input logic [5:0] op, input logic [5:0] fn, input logic z, input int k);
    logic md;
    md = (fn == 6'b011000) || (fn == 6'b011010);
    push(v_fetch(), noise());
    push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 0, 0, 0), noise());
    if (op == 6'b000000) begin
      push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, md, 0, 0), noise());
      if (md) begin
        if (k < T) begin
          for (int i = 0; i <= k; i++)
            push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0, 0, 0), (i == k));
        end else begin
          for (int i = 0; i < T; i++)
            push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 0, 0, 0), 1'b0);
          push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 1), noise());
          return;
        end
      end
      push(ov(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 0, 0, 0), noise());
    end else if (op == 6'b100011 || op == 6'b101011) begin
      push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 0, 0, 0), noise());
      if (op == 6'b100011) begin
        push(ov(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0), noise());
        push(ov(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 0, 0, 0), noise());
      end else begin
        push(ov(0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0), noise());
      end
    end else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010) begin
      push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, imm_class(op), 0, 0, 0), noise());
      push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, imm_class(op), 0, 0, 0), noise());
    end else if (op == 6'b000100 || op == 6'b000101) begin
      push(ov((op == 6'b000100) ? z : ~z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 0, 0, 0),
           noise());
    end else if (op == 6'b000010) begin
      push(ov(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0), noise());
    end else begin
      push(ov(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1, 0), noise());
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cycles(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int n);
    for (int c = 0; c < n && exp_q.size() > 0; c++) begin
      logic [W-1:0] e;
      @(negedge clk);
      if (c == 0) begin
        bus.opcode_i = op;
        bus.funct_i  = fn;
        bus.zero_i   = z;
      end
      bus.alu_done_i = done_q.pop_front();
      e = exp_q.pop_front();
      #1;
      if (c == 0) check($sformatf("%s.start_state", name), 32'(state_o), 32'(S_FETCH));
      check($sformatf("%s.c%0d", name, c + 1), 32'(observed()), 32'(e));
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int k);
    build_plan(op, fn, z, k);
    run_cycles(name, op, fn, z, 1000);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    bus.opcode_i   = 6'd0;
    bus.funct_i    = 6'd0;
    bus.zero_i     = 1'b0;
    bus.alu_done_i = 1'b0;

    @(negedge clk);
    #1 check("reset_outputs", 32'(observed()), 32'(v_fetch()));
    check("reset_state", 32'(state_o), 32'(S_FETCH));
    release_reset();

    run_instr("lw",      6'b100011, 6'd0,      1'b0, 0);
    run_instr("beq_z1",  6'b000100, 6'd0,      1'b1, 0);
    run_instr("bne_z1",  6'b000101, 6'd0,      1'b1, 0);
    run_instr("beq_z0",  6'b000100, 6'd0,      1'b0, 0);
    run_instr("mult_k3", 6'b000000, 6'b011000, 1'b0, 3);
    run_instr("div_to",  6'b000000, 6'b011010, 1'b0, 99);
    run_instr("div_k3",  6'b000000, 6'b011010, 1'b0, T - 1);
    run_instr("mult_k0", 6'b000000, 6'b011000, 1'b0, 0);
    run_instr("ori",     6'b001101, 6'd0,      1'b0, 0);
    run_instr("illegal", 6'b111111, 6'd0,      1'b0, 0);
    run_instr("sw",      6'b101011, 6'd0,      1'b0, 0);
    run_instr("j",       6'b000010, 6'd0,      1'b0, 0);
    run_instr("add",     6'b000000, 6'b100000, 1'b0, 0);

    // lw interrupted by reset while in MEM_READ
    build_plan(6'b100011, 6'd0, 1'b0, 0);
    run_cycles("lw_rst", 6'b100011, 6'd0, 1'b0, 4);
    exp_q.delete();
    done_q.delete();
    #1 rst_n = 1'b0;
    #1 check("rst_async", 32'(observed()), 32'(v_fetch()));
    @(negedge clk);
    #1 check("rst_hold", 32'(observed()), 32'(v_fetch()));
    release_reset();
    run_instr("after_rst", 6'b001000, 6'd0, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int         sel;
      sel = $urandom_range(0, 11);
      case (sel)
        0:  op = 6'b000000;
        1:  op = 6'b100011;
        2:  op = 6'b101011;
        3:  op = 6'b001000;
        4:  op = 6'b001100;
        5:  op = 6'b001101;
        6:  op = 6'b001010;
        7:  op = 6'b000100;
        8:  op = 6'b000101;
        9:  op = 6'b000010;
        10: op = 6'b000000;
        default: op = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 2))
        0:       fn = 6'b011000;
        1:       fn = 6'b011010;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      run_instr($sformatf("rnd%0d_op%02h", n, op), op, fn, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 6)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
